// File: rtl/if_mod.sv
// Instruction-fetch stage: owns the PC, reads a synchronous instruction memory
// and presents one registered instruction per cycle to decode.
module if_mod #(
    parameter int unsigned         PC_W      = 12,
    parameter int unsigned         INSTR_W   = 16,
    parameter logic [PC_W-1:0]     RESET_PC  = '0,
    parameter logic [INSTR_W-1:0]  NOP_INSTR = '0,
    parameter int unsigned         CNT_W     = 16
) (
    input  logic               clk_i,
    input  logic               rst,
    output logic [PC_W-1:0]    imem_adr_o,
    output logic               imem_rd_o,
    input  logic [INSTR_W-1:0] imem_data_i,
    input  logic               stall_i,
    input  logic               jmp_ena_i,
    input  logic [PC_W-1:0]    jmp_adr_i,
    input  logic               end_pr_i,
    output logic [INSTR_W-1:0] instr_o,
    output logic               instr_vld_o,
    output logic [PC_W-1:0]    pc_o,
    output logic               halt_o,
    output logic [CNT_W-1:0]   instr_cnt_o
);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

    state_e             state_q;
    logic [PC_W-1:0]    pc_q;
    logic [PC_W-1:0]    pc_d;
    logic               rd_pend_q;
    logic [PC_W-1:0]    rd_pc_q;
    logic [INSTR_W-1:0] instr_q;
    logic               instr_vld_q;
    logic [PC_W-1:0]    pc_out_q;
    logic               halt_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic               fetch;

    // A read is issued only when nothing redirects, freezes or ends fetch.
    assign fetch     = (state_q == ST_RUN) && !stall_i && !jmp_ena_i && !end_pr_i;
    assign imem_rd_o = fetch;
    assign imem_adr_o = pc_q;

    assign pc_d  = pc_q + PC_W'(1);
    assign cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

    always_ff @(posedge clk_i) begin
        if (rst) begin
            state_q     <= ST_RUN;
            pc_q        <= RESET_PC;
            rd_pend_q   <= 1'b0;
            rd_pc_q     <= '0;
            instr_q     <= NOP_INSTR;
            instr_vld_q <= 1'b0;
            pc_out_q    <= '0;
            halt_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (end_pr_i) begin
                        state_q     <= ST_HALT;
                        rd_pend_q   <= 1'b0;
                        instr_q     <= NOP_INSTR;
                        instr_vld_q <= 1'b0;
                        halt_q      <= 1'b1;
                    end else if (jmp_ena_i) begin
                        // Redirect drops any word still coming back from memory.
                        pc_q        <= jmp_adr_i;
                        rd_pend_q   <= 1'b0;
                        instr_q     <= NOP_INSTR;
                        instr_vld_q <= 1'b0;
                    end else if (!stall_i) begin
                        pc_q      <= pc_d;
                        rd_pend_q <= 1'b1;
                        rd_pc_q   <= pc_q;
                        if (rd_pend_q) begin
                            instr_q     <= imem_data_i;
                            pc_out_q    <= rd_pc_q;
                            instr_vld_q <= 1'b1;
                            cnt_q       <= cnt_d;
                        end else begin
                            instr_q     <= NOP_INSTR;
                            instr_vld_q <= 1'b0;
                        end
                    end
                end
                ST_HALT: begin
                    state_q <= ST_HALT;
                end
                default: begin
                    state_q <= ST_HALT;
                end
            endcase
        end
    end

    assign instr_o     = instr_q;
    assign instr_vld_o = instr_vld_q;
    assign pc_o        = pc_out_q;
    assign halt_o      = halt_q;
    assign instr_cnt_o = cnt_q;

endmodule
